// File: rtl/jt12_i2s_tx_if.sv
// Sample handshake between the channel accumulator and the I2S transmitter.
// The master offers a signed left/right pair; the slave reports holding-register space.
interface jt12_i2s_tx_if #(
    parameter int IN_W = 16
);
    logic signed [IN_W-1:0] left;
    logic signed [IN_W-1:0] right;
    logic                   sample_valid;
    logic                   sample_ready;

    modport master (
        output left, right, sample_valid,
        input  sample_ready
    );

    modport slave (
        input  left, right, sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/jt12_i2s_tx.sv
// I2S transmitter: one-deep holding register feeding a 32-slot frame serialiser
// with a clk_en-based bit-clock divider, underrun reporting and clean frame drain.
module jt12_i2s_tx #(
    parameter int IN_W     = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_en,
    input  logic         en,
    jt12_i2s_tx_if.slave pcm,
    output logic         bclk,
    output logic         lrck,
    output logic         sdata,
    output logic         underrun,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nx;

    logic [7:0]      div;
    logic [4:0]      slot;
    logic [4:0]      slot_inc;
    logic [31:0]     shreg;
    logic [IN_W-1:0] hold_l;
    logic [IN_W-1:0] hold_r;
    logic            full;
    logic            ever;

    logic            active;
    logic            wrap;
    logic            fall;
    logic            stop;
    logic            load;
    logic            accept;
    logic [15:0]     slot_l;
    logic [15:0]     slot_r;

    assign active   = (state != IDLE);
    assign wrap     = clk_en && active && (div == 8'(BCLK_DIV - 1));
    assign fall     = wrap && bclk;
    // The falling edge ending slot 0 either loads a new frame or, when draining, stops.
    assign stop     = fall && (slot == 5'd0) && (state == DRAIN) && !en;
    assign load     = fall && (slot == 5'd0) && !stop;
    assign accept   = clk_en && pcm.sample_valid && !full;
    assign slot_inc = slot + 5'd1;

    assign slot_l = 16'(hold_l) << (16 - IN_W);
    assign slot_r = 16'(hold_r) << (16 - IN_W);

    assign pcm.sample_ready = !full;
    assign sdata            = shreg[31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (!en) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (en) state_nx = RUN;
                else if (stop) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div   <= '0;
            bclk  <= 1'b0;
            slot  <= '0;
            lrck  <= 1'b0;
            shreg <= '0;
        end else if (clk_en && active) begin
            if (stop) begin
                div  <= '0;
                bclk <= 1'b0;
                slot <= '0;
            end else if (wrap) begin
                div  <= '0;
                bclk <= ~bclk;
                if (fall) begin
                    slot <= slot_inc;
                    lrck <= slot_inc[4];
                    if (load) shreg <= {slot_l, slot_r};
                    else      shreg <= {shreg[30:0], 1'b0};
                end
            end else begin
                div <= div + 8'd1;
            end
        end
    end

    // A load with an empty holding register replays the old pair; before the
    // first accept that pair is zero and the miss is not reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_l   <= '0;
            hold_r   <= '0;
            full     <= 1'b0;
            ever     <= 1'b0;
            underrun <= 1'b0;
        end else if (clk_en) begin
            underrun <= load && !full && ever;
            if (accept) begin
                hold_l <= pcm.left;
                hold_r <= pcm.right;
                ever   <= 1'b1;
                full   <= 1'b1;
            end else if (load) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jt12_i2s_tx.sv
// Self-checking bench for jt12_i2s_tx: frame words are queued as expectations
// when pairs are offered and compared as the serial frames are reassembled.
module tb_jt12_i2s_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_en = 1'b1;
    logic en = 1'b0;
    logic en12 = 1'b0;
    logic bclk, lrck, sdata, underrun, busy;
    logic bclk12, lrck12, sdata12, underrun12, busy12;

    jt12_i2s_tx_if #(.IN_W(16)) bus ();
    jt12_i2s_tx_if #(.IN_W(12)) bus12 ();

    jt12_i2s_tx #(.IN_W(16), .BCLK_DIV(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .en(en), .pcm(bus),
        .bclk(bclk), .lrck(lrck), .sdata(sdata), .underrun(underrun), .busy(busy)
    );

    jt12_i2s_tx #(.IN_W(12), .BCLK_DIV(2)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .en(en12), .pcm(bus12),
        .bclk(bclk12), .lrck(lrck12), .sdata(sdata12), .underrun(underrun12), .busy(busy12)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    int          slot_m = 0;
    int          nbits = 0;
    int          ur_cnt = 0;
    int          ur_slot = -1;
    int          cyc = 0;
    int          last_fall = 0;
    int          fall_gap = 0;
    logic        prev_bclk = 1'b0;
    logic [31:0] sh = '0;

    // Every wait goes through here so frame reassembly never misses an edge.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        if (prev_bclk && !bclk) begin
            fall_gap  = cyc - last_fall;
            last_fall = cyc;
            slot_m    = (slot_m + 1) % 32;
            n_checks++;
            if (lrck !== 1'(slot_m >= 16)) begin
                n_fail++;
                $display("FAIL lrck slot %0d: got %b want %b", slot_m, lrck, slot_m >= 16);
            end
            if (slot_m == 1) begin
                sh    = {31'b0, sdata};
                nbits = 1;
            end else if (nbits > 0) begin
                sh    = {sh[30:0], sdata};
                nbits++;
            end
            if (nbits == 32) begin
                nbits = 0;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame: got %h want none queued", sh);
                end else begin
                    e = exp_q.pop_front();
                    if (sh !== e) begin
                        n_fail++;
                        $display("FAIL frame: got %h want %h", sh, e);
                    end
                end
            end
        end
        if (underrun) begin
            ur_cnt++;
            ur_slot = slot_m;
        end
        prev_bclk = bclk;
    endtask

    task automatic wait_slot(input int s);
        int k = 0;
        while (slot_m != s && k < 400) begin
            tick();
            k++;
        end
        n_checks++;
        if (slot_m != s) begin
            n_fail++;
            $display("FAIL wait_slot: got %0d want %0d", slot_m, s);
        end
    endtask

    task automatic wait_frames();
        int k = 0;
        while (exp_q.size() > 0 && k < 800) begin
            tick();
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL frames_timeout: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 400) begin
            tick();
            k++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_timeout: got busy=%b want 0", busy);
        end
    endtask

    task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
        bus.left         = l;
        bus.right        = r;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bclk, lrck, sdata, underrun, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000", {bclk, lrck, sdata, underrun, busy});
        end
        n_checks++;
        if (bus.sample_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", bus.sample_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        send_pair(16'h8001, 16'h7FFE);
        exp_q.push_back(32'h8001_7FFE);
        en = 1'b1;
        wait_slot(3);
        n_checks++;
        if (fall_gap != 4) begin
            n_fail++;
            $display("FAIL bclk_period: got %0d want 4", fall_gap);
        end
        wait_frames();
        n_checks++;
        if (ur_cnt != 0) begin
            n_fail++;
            $display("FAIL underrun_first_load: got %0d want 0", ur_cnt);
        end
    endtask

    task automatic test_repeat();
        int ur0 = ur_cnt;
        exp_q.push_back(32'h8001_7FFE);
        wait_frames();
        n_checks++;
        if (ur_cnt - ur0 != 1) begin
            n_fail++;
            $display("FAIL underrun_repeat: got %0d want 1", ur_cnt - ur0);
        end
        n_checks++;
        if (ur_slot != 1) begin
            n_fail++;
            $display("FAIL underrun_slot: got %0d want 1", ur_slot);
        end
    endtask

    // Offer a pair exactly on the posedge of the next slot-1 load (4 clk after slot 0 entry).
    task automatic test_late_pair();
        int ur0 = ur_cnt;
        exp_q.push_back(32'h8001_7FFE);
        exp_q.push_back(32'h1234_FEDC);
        tick();
        tick();
        tick();
        send_pair(16'h1234, 16'hFEDC);
        n_checks++;
        if (bus.sample_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_load_accept: got %b want 0", bus.sample_ready);
        end
        wait_frames();
        n_checks++;
        if (ur_cnt - ur0 != 1) begin
            n_fail++;
            $display("FAIL underrun_late_pair: got %0d want 1", ur_cnt - ur0);
        end
    endtask

    task automatic test_freeze_drain();
        logic [5:0] snap;
        exp_q.push_back(32'h1234_FEDC);
        wait_slot(3);
        snap   = {bclk, lrck, sdata, busy, bus.sample_ready, underrun};
        clk_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({bclk, lrck, sdata, busy, bus.sample_ready, underrun} !== snap) begin
                n_fail++;
                $display("FAIL freeze: got %b want %b", {bclk, lrck, sdata, busy, bus.sample_ready, underrun}, snap);
            end
        end
        clk_en = 1'b1;
        wait_slot(5);
        en = 1'b0;
        wait_idle();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_frame_complete: got %0d pending want 0", exp_q.size());
        end
        for (int i = 0; i < 8; i++) tick();
        n_checks++;
        if ({bclk, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_drain: got bclk,busy=%b want 00", {bclk, busy});
        end
        slot_m = 0;
        nbits  = 0;
    endtask

    task automatic test_reset_mid();
        int ur0;
        en = 1'b1;
        wait_slot(2);
        send_pair(16'h5555, 16'hAAAA);
        n_checks++;
        if (bus.sample_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_full: got %b want 0", bus.sample_ready);
        end
        wait_slot(20);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bclk, lrck, sdata, underrun, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %b want 00000", {bclk, lrck, sdata, underrun, busy});
        end
        n_checks++;
        if (bus.sample_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_ready: got %b want 1", bus.sample_ready);
        end
        prev_bclk = 1'b0;
        slot_m    = 0;
        nbits     = 0;
        tick();
        rst_n = 1'b1;
        ur0   = ur_cnt;
        exp_q.push_back(32'h0);
        wait_frames();
        n_checks++;
        if (ur_cnt - ur0 != 0) begin
            n_fail++;
            $display("FAIL underrun_after_reset: got %0d want 0", ur_cnt - ur0);
        end
        en = 1'b0;
        wait_idle();
        slot_m = 0;
        nbits  = 0;
    endtask

    task automatic test_in_w12();
        logic        p = 1'b0;
        logic [31:0] w = '0;
        int          s = 0;
        int          k = 0;
        int          u = 0;
        bus12.left         = 12'hABC;
        bus12.right        = 12'h123;
        bus12.sample_valid = 1'b1;
        tick();
        bus12.sample_valid = 1'b0;
        en12 = 1'b1;
        while (s < 32 && k < 400) begin
            tick();
            k++;
            if (p && !bclk12) begin
                s++;
                w = {w[30:0], sdata12};
                if (s == 16) begin
                    n_checks++;
                    if (lrck12 !== 1'b1) begin
                        n_fail++;
                        $display("FAIL w12_lrck_slot16: got %b want 1", lrck12);
                    end
                end
            end
            p = bclk12;
            if (underrun12) u++;
        end
        n_checks++;
        if (w[31:16] !== 16'hABC0) begin
            n_fail++;
            $display("FAIL w12_left: got %h want abc0", w[31:16]);
        end
        n_checks++;
        if (w[15:0] !== 16'h1230) begin
            n_fail++;
            $display("FAIL w12_right: got %h want 1230", w[15:0]);
        end
        n_checks++;
        if (u != 0) begin
            n_fail++;
            $display("FAIL w12_underrun: got %0d want 0", u);
        end
        en12 = 1'b0;
        k = 0;
        while (busy12 && k < 400) begin
            tick();
            k++;
        end
        n_checks++;
        if (busy12 !== 1'b0) begin
            n_fail++;
            $display("FAIL w12_idle: got %b want 0", busy12);
        end
    endtask

    initial begin
        bus.left           = '0;
        bus.right          = '0;
        bus.sample_valid   = 1'b0;
        bus12.left         = '0;
        bus12.right        = '0;
        bus12.sample_valid = 1'b0;
        test_reset();
        test_basic();
        test_repeat();
        test_late_pair();
        test_freeze_drain();
        test_reset_mid();
        test_in_w12();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
